spm_mac: RTL

- Parametrised, handshaked successor to the bit-serial/parallel multiplier.
- Accepts two BITS-wide operands in parallel and multiplies them through an internal chain of delayed serial adder cells, with the multiplicand x shifted in LSB-first.
- Supports unsigned and two's-complement signed modes.
- Optionally accumulates the product into a 2*BITS-wide accumulator and returns the result in parallel over a valid/ready interface.
- Sits between a bus-side register block and the datapath as a self-sequencing MAC.

---
 rtl/spm_mac_pkg.sv | 19 +
 rtl/spm_mac_cell.sv | 30 +++
 rtl/spm_mac.sv | 114 +++++++++++
 3 files changed

// File: rtl/spm_mac_pkg.sv
// rtl/spm_mac_pkg.sv - shared types and timing helpers for the serial/parallel MAC
package spm_mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_BITS = 32;

  function automatic int run_len(input int bits);
    return 2 * bits;
  endfunction

  localparam int RESULT_LATENCY = run_len(DEF_BITS) + 2;

endpackage

// File: rtl/spm_mac_cell.sv
// rtl/spm_mac_cell.sv - delayed serial adder cell of the multiplier chain
module spm_mac_cell (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic x_bit,
  input  logic a_bit,
  input  logic y_in,
  output logic sum
);

  logic       carry;
  logic [1:0] total;

  assign total = {1'b0, x_bit & a_bit} + {1'b0, y_in} + {1'b0, carry};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry <= 1'b0;
      sum   <= 1'b0;
    end else if (clr) begin
      carry <= 1'b0;
      sum   <= 1'b0;
    end else begin
      carry <= total[1];
      sum   <= total[0];
    end
  end

endmodule

// File: rtl/spm_mac.sv
// rtl/spm_mac.sv - handshaked serial/parallel multiply-accumulate engine
module spm_mac
  import spm_mac_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   x,
  input  logic              signed_mode,
  input  logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*BITS-1:0] p,
  output logic              busy
);

  localparam int PW = 2 * BITS;
  localparam int CW = $clog2(run_len(BITS));
  localparam logic [CW-1:0] LAST = CW'(run_len(BITS) - 1);
  localparam logic [CW-1:0] XLEN = CW'(BITS);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] a_q, x_q, a_mag, x_mag, x_sh;
  logic            neg_q, acc_en_q;
  logic [PW-1:0]   prod, prod_full, prod_fix, acc;
  logic [BITS:0]   y_chain;
  logic            accept, x_bit, cell_clr;

  assign in_ready  = (state == IDLE) && !clr;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == FIX);
  assign p         = acc;
  assign accept    = in_valid && in_ready;
  assign cell_clr  = clr || accept;

  // -2^(BITS-1) negates to itself, which is the correct unsigned magnitude
  assign a_mag = (signed_mode && a[BITS-1]) ? (~a + BITS'(1)) : a;
  assign x_mag = (signed_mode && x[BITS-1]) ? (~x + BITS'(1)) : x;

  assign x_sh  = x_q >> cnt;
  assign x_bit = (state == RUN) && (cnt < XLEN) && x_sh[0];

  // cell 0 holds the final product bit only once RUN has ended
  assign prod_full = {y_chain[0], prod[PW-1:1]};
  assign prod_fix  = neg_q ? (~prod_full + PW'(1)) : prod_full;

  assign y_chain[BITS] = 1'b0;

  for (genvar i = 0; i < BITS; i++) begin : g_cell
    spm_mac_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .clr   (cell_clr),
      .x_bit (x_bit),
      .a_bit (a_q[i]),
      .y_in  (y_chain[i+1]),
      .sum   (y_chain[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      a_q      <= '0;
      x_q      <= '0;
      neg_q    <= 1'b0;
      acc_en_q <= 1'b0;
      prod     <= '0;
      acc      <= '0;
    end else if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      if (accept) begin
        a_q      <= a_mag;
        x_q      <= x_mag;
        neg_q    <= signed_mode && (a[BITS-1] ^ x[BITS-1]);
        acc_en_q <= acc_en;
        cnt      <= '0;
      end
      if (state == RUN) begin
        cnt  <= cnt + CW'(1);
        prod <= prod_full;
      end
      if (state == FIX) begin
        acc <= (acc_en_q ? acc : '0) + prod_fix;
      end
    end
  end

endmodule
